// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: MMIO LED controller with per-LED OFF / ON / PWM / BLINK modes.
//
// A prescaler produces a tick that advances a shared 8-bit PWM counter; every
// PWM wrap advances a blink counter that toggles a shared blink phase. Each LED
// output is registered from its mode and this shared time base.
//
// Optional build macro:
//   LED_PWM_GAMMA_EN  - when defined, the effective PWM duty is (DUTY*DUTY)>>8
//                       for perceptual dimming; the DUTY registers still read
//                       back the raw written value. When undefined the duty is
//                       used as written and no multiplier exists.
//
// Register map (address[7:0]):
//   0x00 CTRL      bit0 EN
//   0x04 PRESCALE  [PRESCALE_W-1:0]
//   0x08 MODE      2 bits per LED (0=OFF, 1=ON, 2=PWM, 3=BLINK)
//   0x0C BLINK     [7:0] PWM periods per blink half-phase (minus one)
//   0x20+4*i       DUTY_i [7:0]

module led_pwm_ctrl #(
  parameter int NUM_LEDS   = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_bus_s_rd_en,
  input  logic                io_bus_s_wr_en,
  input  logic                io_bus_s_cs,
  input  logic [31:0]         io_bus_s_address,
  input  logic [31:0]         io_bus_s_wr_data,
  output logic [31:0]         io_bus_s_rd_data,
  output logic [NUM_LEDS-1:0] led
);

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_PRESCALE = 8'h04;
  localparam logic [7:0] ADDR_MODE     = 8'h08;
  localparam logic [7:0] ADDR_BLINK    = 8'h0C;
  localparam logic [7:0] ADDR_DUTY0    = 8'h20;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_PWM   = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  // Byte offset of DUTY_i.
  function automatic logic [7:0] duty_addr(input int i);
    return ADDR_DUTY0 + 8'(4 * i);
  endfunction

  // Configuration registers.
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [2*NUM_LEDS-1:0] mode;
  logic [7:0]            blink;
  logic [7:0]            duty     [NUM_LEDS];
  logic [7:0]            duty_eff [NUM_LEDS];

  // Time base.
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [7:0]            pwm_cnt;
  logic [7:0]            blk_cnt;
  logic                  blink_phase;
  logic                  tick;
  logic                  wrap;

  logic [7:0]            addr;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  wr_ctrl;
  logic                  wr_prescale;
  logic                  en_clr;
  logic [31:0]           rd_mux;
  logic [NUM_LEDS-1:0]   led_next;

  // Upper address bits are not decoded; upper write-data bits only feed
  // registers wide enough to hold them.
  logic                  unused_bus_bits;
  assign unused_bus_bits = ^{io_bus_s_address[31:8], io_bus_s_wr_data[31:8]};

  assign addr        = io_bus_s_address[7:0];
  assign wr_sel      = io_bus_s_cs && io_bus_s_wr_en;
  assign rd_sel      = io_bus_s_cs && io_bus_s_rd_en;
  assign wr_ctrl     = wr_sel && (addr == ADDR_CTRL);
  assign wr_prescale = wr_sel && (addr == ADDR_PRESCALE);
  // Clearing EN zeroes the time base at the write edge itself, not one later.
  assign en_clr      = wr_ctrl && !io_bus_s_wr_data[0];

  // Counter events are evaluated against the configuration before any write
  // landing on the same edge.
  assign tick = en && (pre_cnt == prescale);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Register file writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      prescale <= '0;
      mode     <= '0;
      blink    <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty[i] <= '0;
      end
    end else if (wr_sel) begin
      if (addr == ADDR_CTRL)     en       <= io_bus_s_wr_data[0];
      if (addr == ADDR_PRESCALE) prescale <= io_bus_s_wr_data[PRESCALE_W-1:0];
      if (addr == ADDR_MODE)     mode     <= io_bus_s_wr_data[2*NUM_LEDS-1:0];
      if (addr == ADDR_BLINK)    blink    <= io_bus_s_wr_data[7:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (addr == duty_addr(i)) duty[i] <= io_bus_s_wr_data[7:0];
      end
    end
  end

  // Read mux: unlisted offsets and unused bits return 0.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL:     rd_mux[0]              = en;
      ADDR_PRESCALE: rd_mux[PRESCALE_W-1:0] = prescale;
      ADDR_MODE:     rd_mux[2*NUM_LEDS-1:0] = mode;
      ADDR_BLINK:    rd_mux[7:0]            = blink;
      default:       rd_mux                 = '0;
    endcase
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (addr == duty_addr(i)) rd_mux[7:0] = duty[i];
    end
  end

  // Read data is captured on the strobe edge and held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_bus_s_rd_data <= '0;
    end else if (rd_sel) begin
      io_bus_s_rd_data <= rd_mux;
    end
  end

  // Prescaler, PWM counter and blink generator; all held at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (!en || en_clr) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else begin
      // A PRESCALE write restarts the count so the next tick lands
      // PRESCALE+1 cycles after the write.
      if (wr_prescale || tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_ONE;
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (wrap) begin
        if (blk_cnt == blink) begin
          blk_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blk_cnt <= blk_cnt + 8'd1;
        end
      end
    end
  end

  // Effective duty per LED.
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_duty
`ifdef LED_PWM_GAMMA_EN
    logic [7:0] sq_unused_lsb;
    assign {duty_eff[g], sq_unused_lsb} = 16'(duty[g]) * 16'(duty[g]);
`else
    assign duty_eff[g] = duty[g];
`endif
  end

  // Per-LED output selection from mode and the shared time base.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode[2*i +: 2])
        MODE_OFF:   led_next[i] = 1'b0;
        MODE_ON:    led_next[i] = 1'b1;
        MODE_PWM:   led_next[i] = en && (pwm_cnt < duty_eff[i]);
        MODE_BLINK: led_next[i] = en && blink_phase;
        default:    led_next[i] = 1'b0;
      endcase
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule
